// File: rtl/ddr3_pg_req_initiator.sv
// XDOM-side initiator for the DDR3 page-transfer handshake: one four-phase pg_req/pg_ack
// exchange per page, gated on DPRAM readiness and MIG calibration, with a stall timeout.
module ddr3_pg_req_initiator #(
  parameter int unsigned PG_STRIDE      = 2048,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_start,
  input  logic        cmd_optype,
  input  logic [27:0] cmd_addr,
  input  logic [15:0] cmd_npages,
  input  logic        buf_rdy,
  input  logic        pg_ack,
  input  logic        init_calib_complete,
  output logic        pg_req,
  output logic        pg_optype,
  output logic [27:0] pg_req_addr,
  output logic        busy,
  output logic        pg_cmplt,
  output logic        done,
  output logic [15:0] pages_done,
  output logic        err_timeout
);

  localparam logic [27:0] Stride = 28'(PG_STRIDE);
  localparam logic [15:0] TmoMax = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StWaitBuf,
    StReq,
    StRel,
    StFin,
    StErr
  } state_e;

  state_e      state_q;
  logic [15:0] npages_q;
  logic [15:0] tmo_cnt_q;
  logic        ack_meta_q, ack_s;
  logic        calib_meta_q, calib_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta_q   <= 1'b0;
      ack_s        <= 1'b0;
      calib_meta_q <= 1'b0;
      calib_s      <= 1'b0;
    end else begin
      ack_meta_q   <= pg_ack;
      ack_s        <= ack_meta_q;
      calib_meta_q <= init_calib_complete;
      calib_s      <= calib_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      npages_q    <= '0;
      tmo_cnt_q   <= '0;
      pg_req      <= 1'b0;
      pg_optype   <= 1'b0;
      pg_req_addr <= '0;
      busy        <= 1'b0;
      pg_cmplt    <= 1'b0;
      done        <= 1'b0;
      pages_done  <= '0;
      err_timeout <= 1'b0;
    end else begin
      pg_cmplt <= 1'b0;
      done     <= 1'b0;
      case (state_q)
        // A stalled command parks in StErr; a new strobe is accepted from there directly.
        StIdle, StErr: begin
          if (cmd_start) begin
            pg_optype   <= cmd_optype;
            pg_req_addr <= cmd_addr;
            npages_q    <= cmd_npages;
            pages_done  <= '0;
            err_timeout <= 1'b0;
            busy        <= 1'b1;
            state_q     <= (cmd_npages == 16'd0) ? StFin : StWaitBuf;
          end
        end
        StWaitBuf: begin
          // !ack_s keeps a new request from rising onto a still-high acknowledge.
          if (buf_rdy && calib_s && !ack_s) begin
            pg_req    <= 1'b1;
            tmo_cnt_q <= '0;
            state_q   <= StReq;
          end
        end
        StReq: begin
          if (ack_s) begin
            pg_req    <= 1'b0;
            tmo_cnt_q <= '0;
            state_q   <= StRel;
          end else if (tmo_cnt_q == TmoMax) begin
            pg_req      <= 1'b0;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state_q     <= StErr;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
        StRel: begin
          if (!ack_s) begin
            pg_cmplt    <= 1'b1;
            pages_done  <= pages_done + 16'd1;
            pg_req_addr <= pg_req_addr + Stride;
            state_q     <= (pages_done + 16'd1 == npages_q) ? StFin : StWaitBuf;
          end else if (tmo_cnt_q == TmoMax) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state_q     <= StErr;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
        StFin: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_pg_req_initiator.sv
// Self-checking bench: transaction-level scoreboard of expected page addresses and counts,
// a ui_clk-domain responder with random delays, and directed corner cases.
module tb_ddr3_pg_req_initiator;

  localparam int unsigned Tmo = 100;

  logic        clk = 1'b0, ui_clk = 1'b0, rst_n = 1'b1;
  logic        cmd_start = 1'b0, cmd_optype = 1'b0;
  logic [27:0] cmd_addr = '0;
  logic [15:0] cmd_npages = '0;
  logic        buf_rdy = 1'b1, pg_ack = 1'b0, init_calib_complete = 1'b1;
  logic        pg_req, pg_optype, busy, pg_cmplt, done, err_timeout;
  logic [27:0] pg_req_addr;
  logic [15:0] pages_done;

  ddr3_pg_req_initiator #(.PG_STRIDE(2048), .TIMEOUT_CYCLES(Tmo)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_optype(cmd_optype),
    .cmd_addr(cmd_addr), .cmd_npages(cmd_npages), .buf_rdy(buf_rdy), .pg_ack(pg_ack),
    .init_calib_complete(init_calib_complete), .pg_req(pg_req), .pg_optype(pg_optype),
    .pg_req_addr(pg_req_addr), .busy(busy), .pg_cmplt(pg_cmplt), .done(done),
    .pages_done(pages_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always #3 ui_clk = ~ui_clk;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: what the current command must still request, and what it has completed.
  logic [27:0] exp_q[$];
  logic [27:0] cap[$];
  bit          m_busy = 0, m_optype = 0, expect_to = 0;
  int          m_npages = 0, m_cnt = 0, cmplt_seen = 0, done_cnt = 0;
  int          cyc = 0, last_cmplt_cyc = 0;
  logic        prev_req = 1'b0, prev_buf = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (pg_req) begin
        if (exp_q.size() == 0) check("req_unexpected", pg_req, 0);
        else begin
          check("req_addr", pg_req_addr, exp_q[0]);
          check("req_optype", pg_optype, m_optype);
        end
        check("req_busy", busy, 1);
        if (!prev_req) begin
          check("req_gated_by_buf", prev_buf, 1);
          cap.push_back(pg_req_addr);
        end
      end
      if (pg_cmplt) begin
        m_cnt++;
        cmplt_seen++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check("cmplt_pages_done", pages_done, m_cnt);
        last_cmplt_cyc = cyc;
      end
      if (done) begin
        check("done_expected", m_busy, 1);
        check("done_pages", pages_done, m_npages);
        check("done_queue_empty", exp_q.size(), 0);
        check("done_busy_low", busy, 0);
        if (m_npages > 0) check("done_after_cmplt", cyc - last_cmplt_cyc, 1);
        m_busy = 0;
        done_cnt++;
      end
      if (err_timeout) begin
        check("timeout_expected", expect_to, 1);
        check("err_busy_low", busy, 0);
        check("err_req_low", pg_req, 0);
        m_busy = 0;
      end
      if (!m_busy) check("pages_hold", pages_done, m_cnt);
    end
    prev_req = pg_req;
    prev_buf = buf_rdy;
  end

  // Responder in the ui_clk domain.
  bit resp_en = 1, rand_resp = 0, rand_buf = 0;
  int r_a, r_r, r_k;
  initial forever begin
    @(posedge ui_clk);
    if (pg_req && resp_en) begin
      r_a = rand_resp ? int'($urandom_range(1, 6)) : 5;
      r_r = rand_resp ? int'($urandom_range(1, 6)) : 3;
      repeat (r_a) @(posedge ui_clk);
      pg_ack = 1'b1;
      r_k = 0;
      while (pg_req && r_k < 5000) begin
        @(posedge ui_clk);
        r_k++;
      end
      repeat (r_r) @(posedge ui_clk);
      pg_ack = 1'b0;
    end
  end

  always @(posedge clk) if (rand_buf) #1 buf_rdy = ($urandom_range(0, 3) != 0);

  task automatic start_cmd(input logic opt, input logic [27:0] addr, input int np);
    @(posedge clk) #1;
    cmd_optype = opt;
    cmd_addr   = addr;
    cmd_npages = 16'(np);
    cmd_start  = 1'b1;
    @(posedge clk) #1;
    cmd_start = 1'b0;
    if (!m_busy) begin
      m_busy   = 1;
      m_optype = opt;
      m_npages = np;
      m_cnt    = 0;
      exp_q.delete();
      for (int i = 0; i < np; i++) exp_q.push_back(addr + 28'(i * 2048));
    end
  endtask

  task automatic wait_req(input logic val, input int budget, input string name);
    int i = 0;
    while (pg_req !== val && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (pg_req !== val) check(name, pg_req, val);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i = 0;
    while (m_busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, m_busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0;
    logic [27:0] ra;
    #1 rst_n = 1'b0;
    #20;
    check("rst_pg_req", pg_req, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", pg_req_addr, 0);
    check("rst_pages_done", pages_done, 0);
    check("rst_err", err_timeout, 0);
    check("rst_done", done, 0);
    @(posedge clk) #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Single write page.
    cap.delete();
    start_cmd(1'b1, 28'h0000800, 1);
    wait_idle(300, "single_idle");
    check("single_ncap", cap.size(), 1);
    if (cap.size() >= 1) check("single_addr", cap[0], 28'h0000800);
    check("single_pages_done", pages_done, 1);
    check("single_busy", busy, 0);

    // Three read pages across the 2^28 wrap.
    cap.delete();
    cmplt_seen = 0;
    start_cmd(1'b0, 28'hFFFF000, 3);
    wait_idle(600, "wrap_idle");
    check("wrap_ncap", cap.size(), 3);
    if (cap.size() >= 3) begin
      check("wrap_addr0", cap[0], 28'hFFFF000);
      check("wrap_addr1", cap[1], 28'hFFFF800);
      check("wrap_addr2", cap[2], 28'h0000000);
    end
    check("wrap_cmplts", cmplt_seen, 3);
    check("wrap_pages_done", pages_done, 3);

    // Buffer gating between pages.
    start_cmd(1'b1, 28'h0200000, 2);
    wait_req(1'b1, 100, "gate_req1");
    wait_req(1'b0, 200, "gate_rel1");
    @(posedge clk) #1 buf_rdy = 1'b0;
    n = 0;
    while (!pg_cmplt && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("gate_cmplt1", pg_cmplt, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("gate_req_held", pg_req, 0);
    end
    check("gate_no_timeout", err_timeout, 0);
    @(posedge clk) #1 buf_rdy = 1'b1;
    n = 0;
    while (!pg_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("gate_req_latency", n, 2);
    wait_idle(300, "gate_idle");

    // Calibration low blocks the first request.
    @(posedge clk) #1 init_calib_complete = 1'b0;
    repeat (5) @(posedge clk);
    start_cmd(1'b0, 28'h0300000, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("calib_req_held", pg_req, 0);
    end
    check("calib_busy", busy, 1);
    @(posedge clk) #1 init_calib_complete = 1'b1;
    wait_idle(300, "calib_idle");

    // Zero pages.
    cap.delete();
    start_cmd(1'b1, 28'h0400000, 0);
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("zero_latency_ok", (n <= 3), 1);
    wait_idle(10, "zero_idle");
    check("zero_pages_done", pages_done, 0);
    check("zero_no_req", cap.size(), 0);

    // Command strobe while busy is ignored.
    cap.delete();
    start_cmd(1'b1, 28'h0100000, 2);
    wait_req(1'b1, 100, "abuse_req");
    start_cmd(1'b0, 28'h0AAA000, 5);
    wait_idle(600, "abuse_idle");
    check("abuse_ncap", cap.size(), 2);
    if (cap.size() >= 2) begin
      check("abuse_addr0", cap[0], 28'h0100000);
      check("abuse_addr1", cap[1], 28'h0100800);
    end
    check("abuse_pages_done", pages_done, 2);

    // Timeout with a silent responder, then recovery.
    resp_en   = 0;
    expect_to = 1;
    d0        = done_cnt;
    start_cmd(1'b1, 28'h0123000, 1);
    wait_req(1'b1, 50, "to_req");
    n = 0;
    while (pg_req && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("to_req_cycles", n, Tmo + 1);
    @(negedge clk);
    check("to_err", err_timeout, 1);
    check("to_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("to_err_sticky", err_timeout, 1);
    check("to_no_done", done_cnt, d0);
    resp_en = 1;
    start_cmd(1'b0, 28'h0500000, 2);
    expect_to = 0;
    @(negedge clk);
    check("to_err_cleared", err_timeout, 0);
    check("to_restart_busy", busy, 1);
    wait_idle(600, "to_restart_idle");
    check("to_restart_pages", pages_done, 2);

    // Randomized commands.
    rand_resp = 1;
    rand_buf  = 1;
    for (int c = 0; c < 10; c++) begin
      ra = 28'($urandom());
      start_cmd(1'($urandom_range(0, 1)), ra, int'($urandom_range(0, 4)));
      wait_idle(3000, "rand_idle");
      repeat (int'($urandom_range(1, 5))) @(posedge clk);
    end
    rand_buf = 0;
    @(posedge clk) #1 buf_rdy = 1'b1;
    rand_resp = 0;

    // Asynchronous reset in the middle of a request.
    start_cmd(1'b1, 28'h0600000, 3);
    wait_req(1'b1, 100, "rst_mid_req");
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_pg_req", pg_req, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_pages", pages_done, 0);
    check("rst_mid_addr", pg_req_addr, 0);
    m_busy = 0;
    m_cnt  = 0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    check("rst_mid_ack_clear", pg_ack, 0);
    start_cmd(1'b0, 28'h0700000, 1);
    wait_idle(300, "post_rst_idle");
    check("post_rst_pages", pages_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr3_pg_req_initiator.md
Name: ddr3_pg_req_initiator

Overview:
- XDOM-side initiator for the DDR3 page-transfer handshake.
- Accepts a multi-page command (optype, start address, page count) and issues one four-phase pg_req/pg_ack handshake per page, stepping the DDR3 address by one page each time.
- Gates each page on a local DPRAM buffer-ready signal and reports per-page completion.
- Synchronizes pg_ack and init_calib_complete from the ui_clk domain; times out a stalled responder.

Parameters:
- PG_STRIDE, 2048, DDR3 address increment per page (256 x 128-bit DPRAM = 2048 16-bit column addresses).
- TIMEOUT_CYCLES, 65535, clk cycles allowed in REQ or REL before a timeout error; width 16.

Ports:
- clk  in  1  XDOM clock
- rst_n  in  1  asynchronous active-low reset
- cmd_start  in  1  one-cycle command strobe; ignored unless idle
- cmd_optype  in  1  1 = DPRAM->DDR3 write, 0 = DDR3->DPRAM read
- cmd_addr  in  28  DDR3 address of first page
- cmd_npages  in  16  number of pages to transfer
- buf_rdy  in  1  DPRAM ready for next page (write: filled; read: free)
- pg_ack  in  1  responder acknowledge, asynchronous (ui_clk domain)
- init_calib_complete  in  1  MIG calibration status, asynchronous
- pg_req  out  1  page request level
- pg_optype  out  1  registered cmd_optype
- pg_req_addr  out  28  current page address
- busy  out  1  command in progress
- pg_cmplt  out  1  one-cycle pulse per completed page
- done  out  1  one-cycle pulse at command end (success only)
- pages_done  out  16  pages completed in current/last command
- err_timeout  out  1  sticky timeout flag; cleared by an accepted cmd_start

Behaviour:
- Reset: all outputs 0; state IDLE; both 2-flop synchronizers cleared to 0.
- ack_s and calib_s are 2-flop synchronized copies; pg_ack edge visible to the FSM 2 clk later.
- IDLE: cmd_start=1 latches optype/addr/npages, clears pages_done and err_timeout, sets busy next cycle. If cmd_npages=0, go to FIN. Otherwise go to WAIT_BUF.
- WAIT_BUF: when buf_rdy=1 and calib_s=1, go to REQ, loading the timeout counter to 0.
- REQ: pg_req=1. pg_req_addr and pg_optype stable throughout. On ack_s=1 go to REL with counter reset.
- REL: pg_req=0. On ack_s=0, pulse pg_cmplt, increment pages_done, and add PG_STRIDE to pg_req_addr (modulo 2^28, wraps silently). Then:
  - pages_done+1 == npages -> FIN;
  - otherwise -> WAIT_BUF.
- FIN: pulse done for 1 cycle, clear busy, go to IDLE.
- Timeout: in REQ or REL, when the counter reaches TIMEOUT_CYCLES, go to ERR. ERR: pg_req=0, err_timeout=1, busy=0, no done pulse. ERR returns to IDLE only on cmd_start, which is then accepted as a new command in the same cycle.
- The counter increments every cycle in REQ/REL and saturates. Timeout is not counted in WAIT_BUF.
- cmd_start while busy: ignored, no effect on latched fields.
- pg_req never rises while ack_s=1. A new page waits in WAIT_BUF until ack_s=0, which is guaranteed by the REL exit.
- Asynchronous reset mid-handshake drops pg_req immediately. The responder completes its half and returns pg_ack low on its own.
- pages_done holds its final value after done or err until the next accepted cmd_start.

Test Plan:
- Single write page: cmd_addr=0x0000800, npages=1, optype=1, buf_rdy=1, calib=1; responder acks 5 clk after pg_req, releases 3 clk after drop -> pg_req_addr=0x0000800 during REQ; pg_cmplt then done one cycle later; pages_done=1; busy low after done.
- Three read pages with address wrap: cmd_addr=0xFFFF000, npages=3 -> request addresses 0xFFFF000, 0xFFFF800, 0x0000000; three pg_cmplt pulses; pages_done=3; pg_optype=0 throughout.
- Buffer gating: buf_rdy held low 20 clk between pages -> pg_req stays 0 the whole time; no timeout; request issued 1 clk after buf_rdy=1 is sampled. calib low likewise blocks the first request.
- Zero pages: npages=0 -> done pulses within 3 clk of cmd_start; pg_req never asserted; pages_done=0.
- Timeout: TIMEOUT_CYCLES=100, responder never acks -> pg_req falls at ~101 clk; err_timeout=1; busy=0; no done pulse. A new cmd_start clears err_timeout and restarts the sequence.
- Abuse: cmd_start pulsed during REQ with different addr -> ignored, original sequence completes. rst_n asserted during REQ -> pg_req=0 and busy=0 immediately (asynchronous); all outputs at reset values.
